// File: rtl/keccak_byte_packer.sv
// Byte-wide AXI4-Stream to DWIDTH-bit word packer feeding the Keccak core sink.
// Bytes pack little-endian; t_keep stays contiguous from lane 0 and the output word is fully registered.
module keccak_byte_packer #(
    parameter int DWIDTH = 64,
    localparam int KEEP_WIDTH = DWIDTH / 8,
    localparam int CNT_WIDTH = $clog2(KEEP_WIDTH + 1)
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic [7:0]            s_data_i,
    input  logic                  s_valid_i,
    input  logic                  s_keep_i,
    input  logic                  s_last_i,
    output logic                  s_ready_o,
    output logic [DWIDTH-1:0]     m_data_o,
    output logic                  m_valid_o,
    output logic [KEEP_WIDTH-1:0] m_keep_o,
    output logic                  m_last_o,
    input  logic                  m_ready_i
);

    logic [DWIDTH-1:0]     acc_data_reg;
    logic [CNT_WIDTH-1:0]  acc_cnt_reg;
    logic                  out_valid_reg;
    logic [DWIDTH-1:0]     out_data_reg;
    logic [KEEP_WIDTH-1:0] out_keep_reg;
    logic                  out_last_reg;

    logic                  accept;
    logic                  complete;
    logic [CNT_WIDTH-1:0]  byte_cnt;
    logic [DWIDTH-1:0]     merged_data;
    logic [KEEP_WIDTH-1:0] merged_keep;

    // Stalling every input beat while a word waits keeps accumulator and output coherent.
    assign s_ready_o = !out_valid_reg || m_ready_i;
    assign accept    = s_valid_i && s_ready_o;
    assign byte_cnt  = acc_cnt_reg + CNT_WIDTH'(s_keep_i);
    assign complete  = accept &&
                       (s_last_i || (s_keep_i && acc_cnt_reg == CNT_WIDTH'(KEEP_WIDTH - 1)));

    generate
        for (genvar gi = 0; gi < KEEP_WIDTH; gi++) begin : g_lane
            assign merged_data[8*gi +: 8] = (s_keep_i && acc_cnt_reg == CNT_WIDTH'(gi)) ?
                                            s_data_i : acc_data_reg[8*gi +: 8];
            assign merged_keep[gi]        = byte_cnt > CNT_WIDTH'(gi);
        end
    endgenerate

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            acc_data_reg  <= '0;
            acc_cnt_reg   <= '0;
            out_valid_reg <= 1'b0;
            out_data_reg  <= '0;
            out_keep_reg  <= '0;
            out_last_reg  <= 1'b0;
        end else if (complete) begin
            // Lanes above the count are still zero because the accumulator clears on every word.
            out_valid_reg <= 1'b1;
            out_data_reg  <= merged_data;
            out_keep_reg  <= merged_keep;
            out_last_reg  <= s_last_i;
            acc_data_reg  <= '0;
            acc_cnt_reg   <= '0;
        end else begin
            if (m_ready_i) begin
                out_valid_reg <= 1'b0;
            end
            if (accept && s_keep_i) begin
                acc_data_reg <= merged_data;
                acc_cnt_reg  <= acc_cnt_reg + 1'b1;
            end
        end
    end

    assign m_valid_o = out_valid_reg;
    assign m_data_o  = out_data_reg;
    assign m_keep_o  = out_keep_reg;
    assign m_last_o  = out_last_reg;

endmodule
